// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer with a valid/ready handshake.
// SKID=1 gives a two-entry buffer whose in_ready_o comes straight from a
// flop; SKID=0 gives a single register with combinational in_ready_o.
// Flushed or empty entries hold NOP_VALUE. A saturating counter records
// cycles in which downstream was ready but nothing was presented.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_EMPTY | no payload held, out_valid_o=0
//   ST_ONE   | main entry M holds a payload, presented downstream
//   ST_FULL  | M and skid entry S both hold payloads (SKID=1 only)
module pipe_stage_buf #(
  parameter int unsigned      WIDTH     = 32,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  // The state encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] bub_q;
  logic             m_v;
  logic             in_fire;
  logic             out_fire;

  assign m_v      = (state_q != ST_EMPTY);
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = m_v & out_ready_i;

  assign out_valid_o  = m_v;
  assign out_data_o   = m_v ? m_q : NOP_VALUE;
  assign count_o      = state_q;
  assign bubble_cnt_o = bub_q;

  generate
    if (SKID) begin : g_skid
      logic rdy_q;

      // Registered ready: low in reset, then tracks "skid entry free" for the next cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdy_q <= 1'b0;
        end else begin
          rdy_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready_o = rdy_q;
    end else begin : g_noskid
      logic alive_q;

      // Holds ready low until the first edge after reset release.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          alive_q <= 1'b0;
        end else begin
          alive_q <= 1'b1;
        end
      end

      assign in_ready_o = alive_q & (!m_v | out_ready_i);
    end
  endgenerate

  // State and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      m_q     <= NOP_VALUE;
      s_q     <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  // Next-state and storage update; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      m_d     = NOP_VALUE;
      s_d     = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_d     = in_data_i;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_d = in_data_i;
          end else if (in_fire) begin
            // Without a skid entry ready implies out_ready_i, so this arm is SKID-only.
            if (SKID) begin
              s_d     = in_data_i;
              state_d = ST_FULL;
            end
          end else if (out_fire) begin
            m_d     = NOP_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            m_d     = s_q;
            s_d     = NOP_VALUE;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          m_d     = NOP_VALUE;
          s_d     = NOP_VALUE;
        end
      endcase
    end
  end

  // Bubble counter: downstream ready with nothing presented; saturates, survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bub_q <= '0;
    end else if (out_ready_i && !m_v && (bub_q != {CNT_W{1'b1}})) begin
      bub_q <= bub_q + CNT_W'(1);
    end
  end

endmodule
